// File: rtl/rd_buffer_pkg.sv
// Shared definitions for the read-data buffer: AHB size codes, default
// geometry and the byte-lane helpers used when capturing HRDATA beats.
package rd_buffer_pkg;

    localparam logic [2:0] P_B8  = 3'b000;
    localparam logic [2:0] P_B16 = 3'b001;
    localparam logic [2:0] P_B32 = 3'b010;

    localparam int P_DEPTH    = 16;
    localparam int P_AW       = 4;
    localparam int P_AF_LEVEL = 12;

    // Lane pointer step after each captured (or dropped) beat.
    function automatic logic [1:0] lane_advance(input logic [1:0] lane,
                                                input logic [2:0] size);
        case (size)
            P_B8:    return lane + 2'd1;
            P_B16:   return lane + 2'd2;
            default: return lane;
        endcase
    endfunction

    // Halfword starts round up so they line up with the interface's aligned address.
    function automatic logic [1:0] lane_start(input logic [1:0] addr,
                                              input logic [2:0] size);
        case (size)
            P_B8:    return addr;
            P_B16:   return addr + {1'b0, addr[0]};
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] data,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  size);
        logic [31:0] shifted;
        shifted = data >> {lane, 3'b000};
        case (size)
            P_B8:    return {24'h0, shifted[7:0]};
            P_B16:   return {16'h0, (lane[1] ? data[31:16] : data[15:0])};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/rd_buffer_mem.sv
// Storage array for the read-data buffer: synchronous write, asynchronous
// read so the head element can fall through to the output without a cycle of latency.
module rd_buffer_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rd_buffer.sv
// Read-data buffer behind the AHB master: extracts the active lanes of each
// HRDATA beat and queues them first-word-fall-through for the rotate core.
module rd_buffer
    import rd_buffer_pkg::*;
#(
    parameter int DEPTH    = P_DEPTH,
    parameter int AW       = P_AW,
    parameter int AF_LEVEL = P_AF_LEVEL
) (
    input  logic          I_RDBUF_HCLK,
    input  logic          I_RDBUF_HRESET_N,
    input  logic          I_RDBUF_RESET,
    input  logic          I_RDBUF_START,
    input  logic [1:0]    I_RDBUF_ADDR,
    input  logic [2:0]    I_RDBUF_SIZE,
    input  logic [31:0]   I_RDBUF_HRDATA,
    input  logic          I_RDBUF_BUFF_WRITE,
    input  logic          I_RDBUF_HREADY,
    input  logic          I_RDBUF_POP,
    output logic [31:0]   O_RDBUF_DATA,
    output logic          O_RDBUF_VALID,
    output logic          O_RDBUF_FULL,
    output logic          O_RDBUF_AFULL,
    output logic [AW:0]   O_RDBUF_LEVEL,
    output logic          O_RDBUF_OVERFLOW
);

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AFULL = (AW+1)'(AF_LEVEL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic [1:0]    lane_q,   lane_d;
    logic          ovf_q,    ovf_d;

    logic          push;
    logic          pop_eff;
    logic          wr_en;
    logic          valid;
    logic          full;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;

    assign valid   = (level_q != '0);
    assign full    = (level_q == LVL_FULL);
    assign push    = I_RDBUF_BUFF_WRITE & I_RDBUF_HREADY;
    assign pop_eff = I_RDBUF_POP & valid;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign wr_en   = push & (~full | pop_eff) & ~I_RDBUF_RESET;
    assign wr_data = lane_extract(I_RDBUF_HRDATA, lane_q, I_RDBUF_SIZE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        lane_d   = lane_q;
        ovf_d    = ovf_q;
        if (I_RDBUF_RESET) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            lane_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop_eff) begin
                level_d = level_q + 1'b1;
            end else if (!wr_en && pop_eff) begin
                level_d = level_q - 1'b1;
            end
            if (push && !wr_en) begin
                ovf_d = 1'b1;
            end
            // START wins over the advance; a coincident beat already used the old lane.
            if (I_RDBUF_START) begin
                lane_d = lane_start(I_RDBUF_ADDR, I_RDBUF_SIZE);
            end else if (push) begin
                lane_d = lane_advance(lane_q, I_RDBUF_SIZE);
            end
        end
    end

    always_ff @(posedge I_RDBUF_HCLK or negedge I_RDBUF_HRESET_N) begin
        if (!I_RDBUF_HRESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lane_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            lane_q   <= lane_d;
            ovf_q    <= ovf_d;
        end
    end

    rd_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (I_RDBUF_HCLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign O_RDBUF_DATA     = valid ? rd_data : 32'h0;
    assign O_RDBUF_VALID    = valid;
    assign O_RDBUF_FULL     = full;
    assign O_RDBUF_AFULL    = (level_q >= LVL_AFULL);
    assign O_RDBUF_LEVEL    = level_q;
    assign O_RDBUF_OVERFLOW = ovf_q;

endmodule

// File: tb/tb_rd_buffer.sv
// Self-checking bench for rd_buffer: lane-extraction vector table plus
// scoreboarded sequences for full/overflow, wrap, soft and async reset.
module tb_rd_buffer;

    logic        hclk;
    logic        hreset_n;
    logic        soft_rst;
    logic        start;
    logic [1:0]  addr;
    logic [2:0]  size;
    logic [31:0] hrdata;
    logic        buff_write;
    logic        hready;
    logic        pop;
    logic [31:0] data_o;
    logic        valid_o;
    logic        full_o;
    logic        afull_o;
    logic [4:0]  level_o;
    logic        ovf_o;

    rd_buffer dut (
        .I_RDBUF_HCLK       (hclk),
        .I_RDBUF_HRESET_N   (hreset_n),
        .I_RDBUF_RESET      (soft_rst),
        .I_RDBUF_START      (start),
        .I_RDBUF_ADDR       (addr),
        .I_RDBUF_SIZE       (size),
        .I_RDBUF_HRDATA     (hrdata),
        .I_RDBUF_BUFF_WRITE (buff_write),
        .I_RDBUF_HREADY     (hready),
        .I_RDBUF_POP        (pop),
        .O_RDBUF_DATA       (data_o),
        .O_RDBUF_VALID      (valid_o),
        .O_RDBUF_FULL       (full_o),
        .O_RDBUF_AFULL      (afull_o),
        .O_RDBUF_LEVEL      (level_o),
        .O_RDBUF_OVERFLOW   (ovf_o)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        bit          do_start;
        logic [1:0]  addr;
        logic [2:0]  size;
        logic [31:0] hrdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] sb_q [$];
    int          m_level;
    bit          m_ovf;
    int          errors;
    int          checks;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] head;
        head = (sb_q.size() > 0) ? sb_q[0] : 32'h0;
        chk({tag, "_level"}, 32'(level_o), 32'(m_level));
        chk({tag, "_valid"}, 32'(valid_o), 32'(m_level != 0));
        chk({tag, "_full"},  32'(full_o),  32'(m_level == 16));
        chk({tag, "_afull"}, 32'(afull_o), 32'(m_level >= 12));
        chk({tag, "_ovf"},   32'(ovf_o),   32'(m_ovf));
        chk({tag, "_data"},  data_o, head);
    endtask

    // One bus cycle: scoreboard is updated from the reference rules, then DUT state compared.
    task automatic step(input bit pu, input bit po, input logic [31:0] d,
                        input logic [31:0] e, input bit st);
        bit pe;
        bit acc;
        logic [31:0] popped;
        pe  = po && (m_level != 0);
        acc = pu && ((m_level < 16) || pe);
        if (pe) begin
            chk("pop_head", data_o, sb_q[0]);
            popped = sb_q.pop_front();
        end
        if (acc) sb_q.push_back(e);
        else if (pu) m_ovf = 1'b1;
        m_level = m_level + (acc ? 1 : 0) - (pe ? 1 : 0);
        buff_write = pu;
        hready     = 1'b1;
        pop        = po;
        hrdata     = d;
        start      = st;
        tick();
        buff_write = 1'b0;
        pop        = 1'b0;
        start      = 1'b0;
        $display("step push=%0d pop=%0d hrdata=%h level=%0d data=%h", pu, po, d, level_o, data_o);
        chk_status("step");
    endtask

    task automatic do_start(input logic [1:0] a, input logic [2:0] s);
        addr  = a;
        size  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        while (m_level > 0) step(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        errors = 0; checks = 0; m_level = 0; m_ovf = 1'b0;
        hreset_n = 1'b0; soft_rst = 1'b0; start = 1'b0; addr = 2'd0;
        size = 3'b010; hrdata = 32'h0; buff_write = 1'b0; hready = 1'b0; pop = 1'b0;

        tbl[0] = '{1'b1, 2'd0, 3'b010, 32'h11223344, 32'h11223344};
        tbl[1] = '{1'b0, 2'd0, 3'b010, 32'h22334455, 32'h22334455};
        tbl[2] = '{1'b0, 2'd0, 3'b010, 32'h33445566, 32'h33445566};
        tbl[3] = '{1'b0, 2'd0, 3'b010, 32'h44556677, 32'h44556677};
        tbl[4] = '{1'b1, 2'd2, 3'b000, 32'hDDCCBBAA, 32'h000000CC};
        tbl[5] = '{1'b0, 2'd2, 3'b000, 32'hDDCCBBAA, 32'h000000DD};
        tbl[6] = '{1'b0, 2'd2, 3'b000, 32'hDDCCBBAA, 32'h000000AA};
        tbl[7] = '{1'b0, 2'd2, 3'b000, 32'hDDCCBBAA, 32'h000000BB};
        tbl[8] = '{1'b1, 2'd1, 3'b001, 32'h87654321, 32'h00008765};
        tbl[9] = '{1'b0, 2'd1, 3'b001, 32'h87654321, 32'h00004321};

        repeat (2) tick();
        $display("reset asserted");
        chk_status("reset");
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();

        // Lane extraction table: word, byte from lane 2, half from ADDR=1 (lane 2).
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].do_start) do_start(tbl[i].addr, tbl[i].size);
            step(1'b1, 1'b0, tbl[i].hrdata, tbl[i].exp, 1'b0);
        end
        drain();

        // START coincident with a push: the beat takes the old lane.
        do_start(2'd0, 3'b000);
        step(1'b1, 1'b0, 32'h44332211, 32'h00000011, 1'b0);
        addr = 2'd3;
        step(1'b1, 1'b0, 32'h44332211, 32'h00000022, 1'b1);
        step(1'b1, 1'b0, 32'h44332211, 32'h00000044, 1'b0);
        drain();

        // Beat without HREADY must not be written.
        buff_write = 1'b1; hready = 1'b0; hrdata = 32'hBAD0BAD0;
        tick();
        buff_write = 1'b0;
        $display("no-ready beat level=%0d", level_o);
        chk_status("noready");

        // Fill to full, drop one beat, then push+pop while full.
        do_start(2'd0, 3'b010);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i + 1), 32'(i + 1), 1'b0);
        step(1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        step(1'b1, 1'b1, 32'h00000100, 32'h00000100, 1'b0);
        drain();

        // Soft reset at level 7 with overflow set and a concurrent push.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i), 32'hA0 + 32'(i), 1'b0);
        soft_rst = 1'b1; buff_write = 1'b1; hready = 1'b1; hrdata = 32'h55555555;
        tick();
        soft_rst = 1'b0; buff_write = 1'b0;
        m_level = 0; m_ovf = 1'b0; sb_q.delete();
        $display("soft reset level=%0d ovf=%0d", level_o, ovf_o);
        chk_status("softrst");

        // Wrap: pointers advance 10, then push+pop into empty, then steady push+pop.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h1000 + 32'(i), 32'h1000 + 32'(i), 1'b0);
        drain();
        step(1'b1, 1'b1, 32'h2000, 32'h2000, 1'b0);
        step(1'b1, 1'b0, 32'h2001, 32'h2001, 1'b0);
        step(1'b1, 1'b0, 32'h2002, 32'h2002, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'h3000 + 32'(i), 32'h3000 + 32'(i), 1'b0);

        // Async reset away from any clock edge.
        #3;
        hreset_n = 1'b0;
        #1;
        m_level = 0; m_ovf = 1'b0; sb_q.delete();
        $display("async reset level=%0d valid=%0d", level_o, valid_o);
        chk_status("arst");
        @(negedge hclk);
        hreset_n = 1'b1;
        tick();
        chk_status("post_arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rd_buffer.md
Name: rd_buffer

Overview:
- Read-data buffer directly downstream of the AHB master interface.
- Captures HRDATA beats qualified by the interface's buffer-write strobe and HREADY.
- Extracts the active byte lane(s) per transfer size and stores zero-extended elements in a FIFO.
- Presents them first-word-fall-through to the rotate core, with full/almost-full/level status for core throttling.

Parameters:
- DEPTH, 16, FIFO entries (power of two).
- AW, 4, log2(DEPTH); pointer width.
- AF_LEVEL, 12, almost-full threshold (O_RDBUF_AFULL when level >= AF_LEVEL).

Ports:
- I_RDBUF_HCLK  in  1  bus clock; all state on rising edge.
- I_RDBUF_HRESET_N  in  1  asynchronous active-low reset.
- I_RDBUF_RESET  in  1  soft reset from register file; synchronous flush.
- I_RDBUF_START  in  1  start pulse; loads byte-lane pointer.
- I_RDBUF_ADDR  in  2  low bits of start address from core.
- I_RDBUF_SIZE  in  3  transfer size: 000 byte, 001 half, 010 word.
- I_RDBUF_HRDATA  in  32  AHB read data.
- I_RDBUF_BUFF_WRITE  in  1  buffer-write strobe from AHB interface.
- I_RDBUF_HREADY  in  1  AHB data-phase ready.
- I_RDBUF_POP  in  1  core consumes head element.
- O_RDBUF_DATA  out  32  head element, zero-extended.
- O_RDBUF_VALID  out  1  FIFO not empty.
- O_RDBUF_FULL  out  1  level == DEPTH.
- O_RDBUF_AFULL  out  1  level >= AF_LEVEL.
- O_RDBUF_LEVEL  out  AW+1  occupancy, 0..DEPTH.
- O_RDBUF_OVERFLOW  out  1  sticky; a beat was dropped.

Behaviour:
- Async reset: pointers, level, lane pointer and overflow cleared; memory not reset. Outputs: DATA=0 (empty gating), VALID=0, FULL=0, AFULL=0, LEVEL=0, OVERFLOW=0.
- Soft reset (I_RDBUF_RESET=1 at an edge) has the same effect synchronously and has priority over push, pop and start.
- push = BUFF_WRITE & HREADY. pop_eff = POP & VALID; POP while empty is ignored.
- Write on push when (!FULL | pop_eff). Push while FULL without pop: beat dropped, OVERFLOW <= 1, held until reset or soft reset.
- Level update:
  - push & pop_eff both effective: level unchanged.
  - Otherwise +1 on push, -1 on pop_eff.
  - Pointers wrap modulo DEPTH.
- FWFT, no same-cycle bypass:
  - An element written at edge N appears on DATA/VALID after edge N.
  - A push into an empty FIFO concurrent with POP does not pop.
- DATA = mem[rd_ptr] when VALID, else 32'h0.
- Lane pointer (2 bits):
  - Loaded on START:
    - byte: ADDR.
    - half: (ADDR + ADDR[0]) mod 4, rounding up to match the interface's address alignment.
    - word / other size: 0.
  - Advanced after each effective or dropped push: +1 byte, +2 half, +0 word, modulo 4.
  - START coincident with push: the pushed beat uses the old lane; the pointer then loads the new value.
- Extraction, little-endian:
  - byte: {24'h0, HRDATA[8*lane +: 8]}.
  - half: {16'h0, HRDATA[16*lane[1] +: 16]}.
  - word and sizes 011..111: HRDATA.
- SIZE and START are quasi-static during a burst; mid-burst SIZE change takes effect on the next push using the current lane pointer.

Decomposition:
- Shared package holds:
  - size codes (P_B8/P_B16/P_B32), identical to the AHB interface encoding.
  - DEPTH/AF_LEVEL defaults.
  - a lane-advance function.
- One sub-module is natural: rd_buffer_mem, a DEPTH x 32 register array with write enable/address and asynchronous read address.
- Lane extraction, pointers and status stay in the top.

Test Plan:
- Word reads: SIZE=010, 4 pushes 32'h11223344..44556677 with no pop -> LEVEL=4, VALID=1, DATA=32'h11223344; 4 pops return the words in order, then VALID=0 and DATA=0.
- Byte lanes: START with ADDR=2, SIZE=000, 4 pushes of 32'hDDCCBBAA -> stored 32'hCC, 32'hDD, 32'hAA, 32'hBB.
- Half lanes: START with ADDR=1, SIZE=001 (lane 2), 2 pushes of 32'h87654321 -> 32'h8765 then 32'h4321.
- Full/overflow:
  - 16 pushes -> FULL=1, AFULL=1 (AFULL first set at level 12).
  - 17th push with no pop -> OVERFLOW=1, LEVEL=16, beat dropped.
  - Next push with POP -> accepted, LEVEL stays 16.
- Wrap and simultaneity: 10 pushes, 10 pops, then continuous push+pop for 20 cycles -> LEVEL constant and order preserved across pointer wrap; HREADY=0 with BUFF_WRITE=1 -> no write.
- Resets:
  - Soft reset at LEVEL=7 with OVERFLOW=1 and concurrent push -> next cycle LEVEL=0, VALID=0, OVERFLOW=0.
  - Asynchronous HRESET_N asserted mid-cycle -> outputs cleared without waiting for a clock edge.
